// File: rtl/operand_fetch_stage_if.sv
// Bundle of decode-side, register-file, writeback and EX-side signals of the operand fetch stage.
// The stage itself connects through the slave modport; its environment uses master.
interface operand_fetch_stage_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
);
    // decode side
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic [XLEN-1:0]   in_imm;
    logic [CTRL_W-1:0] in_ctrl;

    // register file read port
    logic [REG_AW-1:0] rf_rs1;
    logic [REG_AW-1:0] rf_rs2;
    logic [XLEN-1:0]   rf_rdata1;
    logic [XLEN-1:0]   rf_rdata2;

    // writeback port, shared with the register file write side
    logic              wb_regWrite;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;

    // EX side
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_op1;
    logic [XLEN-1:0]   out_op2;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [REG_AW-1:0] out_rd;
    logic [XLEN-1:0]   out_imm;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  flush, in_valid, in_rs1, in_rs2, in_rd, in_imm, in_ctrl,
        input  rf_rdata1, rf_rdata2,
        input  wb_regWrite, wb_rd, wb_data,
        input  out_ready,
        output in_ready, rf_rs1, rf_rs2,
        output out_valid, out_op1, out_op2, out_rs1, out_rs2, out_rd, out_imm, out_ctrl
    );

    modport master (
        output flush, in_valid, in_rs1, in_rs2, in_rd, in_imm, in_ctrl,
        output rf_rdata1, rf_rdata2,
        output wb_regWrite, wb_rd, wb_data,
        output out_ready,
        input  in_ready, rf_rs1, rf_rs2,
        input  out_valid, out_op1, out_op2, out_rs1, out_rs2, out_rd, out_imm, out_ctrl
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// ID/EX operand fetch stage: reads rs1/rs2 from the register file, bypasses same-cycle
// writeback, and keeps held operands coherent by snooping writeback while stalled.
module operand_fetch_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    operand_fetch_stage_if.slave  bus
);

    logic              valid_q, valid_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    logic in_ready;
    logic accept;
    logic hold;

    logic [REG_AW-1:0] in_rs [2];
    logic [XLEN-1:0]   rf_rdata [2];

    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign hold     = valid_q && !bus.out_ready;

    assign in_rs[0]    = bus.in_rs1;
    assign in_rs[1]    = bus.in_rs2;
    assign rf_rdata[0] = bus.rf_rdata1;
    assign rf_rdata[1] = bus.rf_rdata2;

    // One identical lane per source operand: address, captured value and snoop.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic [REG_AW-1:0] rs_q, rs_d;
            logic [XLEN-1:0]   op_q, op_d;
            logic              wb_hits_in;
            logic              wb_hits_held;

            // x0 never matches, so a writeback to register 0 is invisible here.
            assign wb_hits_in   = bus.wb_regWrite && (bus.wb_rd == in_rs[gi])
                                  && (in_rs[gi] != '0);
            assign wb_hits_held = bus.wb_regWrite && (bus.wb_rd == rs_q)
                                  && (rs_q != '0);

            always_comb begin
                rs_d = rs_q;
                op_d = op_q;
                if (accept) begin
                    rs_d = in_rs[gi];
                    if (in_rs[gi] == '0) begin
                        op_d = '0;
                    end else if (wb_hits_in) begin
                        op_d = bus.wb_data;
                    end else begin
                        op_d = rf_rdata[gi];
                    end
                end else if (hold && wb_hits_held) begin
                    op_d = bus.wb_data;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rs_q <= '0;
                    op_q <= '0;
                end else begin
                    rs_q <= rs_d;
                    op_q <= op_d;
                end
            end
        end
    endgenerate

    // A flush wins over a same-cycle accept; captured data then sits unused.
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        if (accept) begin
            rd_d   = bus.in_rd;
            imm_d  = bus.in_imm;
            ctrl_d = bus.in_ctrl;
        end
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.rf_rs1    = bus.in_rs1;
    assign bus.rf_rs2    = bus.in_rs2;
    assign bus.out_valid = valid_q;
    assign bus.out_op1   = g_opnd[0].op_q;
    assign bus.out_op2   = g_opnd[1].op_q;
    assign bus.out_rs1   = g_opnd[0].rs_q;
    assign bus.out_rs2   = g_opnd[1].rs_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_imm   = imm_q;
    assign bus.out_ctrl  = ctrl_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios followed by random traffic, all checked
// against an architectural model where a held operand must equal the current value of its register.
module tb_operand_fetch_stage;

    logic clk;
    logic reset;

    operand_fetch_stage_if #(.XLEN(64), .REG_AW(5), .CTRL_W(16)) bus ();

    operand_fetch_stage #(.XLEN(64), .REG_AW(5), .CTRL_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file contents; only ever changed by writebacks once traffic starts.
    logic [63:0] rf_mem [32];
    assign bus.rf_rdata1 = rf_mem[bus.rf_rs1];
    assign bus.rf_rdata2 = rf_mem[bus.rf_rs2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what EX should be looking at.
    logic        m_v;
    logic        m_clear;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [63:0] m_imm;
    logic [15:0] m_ctrl;

    function automatic logic [63:0] arch(input logic [4:0] idx);
        return (idx == 5'd0) ? 64'd0 : rf_mem[idx];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic cycle();
        logic        exp_ready, acc, rst, fl;
        logic        we;
        logic [4:0]  wrd, rs1, rs2, rd;
        logic [63:0] wdata, imm;
        logic [15:0] ctrl;
        #1;
        exp_ready = !m_v || bus.out_ready;
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
        chk("rf_rs1", {59'd0, bus.rf_rs1}, {59'd0, bus.in_rs1});
        chk("rf_rs2", {59'd0, bus.rf_rs2}, {59'd0, bus.in_rs2});
        acc = bus.in_valid && exp_ready;
        rst = reset;  fl = bus.flush;
        we = bus.wb_regWrite;  wrd = bus.wb_rd;  wdata = bus.wb_data;
        rs1 = bus.in_rs1;  rs2 = bus.in_rs2;  rd = bus.in_rd;
        imm = bus.in_imm;  ctrl = bus.in_ctrl;
        @(posedge clk);
        #1;
        if (we && wrd != 5'd0) rf_mem[wrd] = wdata;
        m_clear = rst;
        if (rst) begin
            m_v = 1'b0; m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_imm = '0; m_ctrl = '0;
        end else if (fl) begin
            m_v = 1'b0;
        end else if (acc) begin
            m_v = 1'b1; m_rs1 = rs1; m_rs2 = rs2; m_rd = rd; m_imm = imm; m_ctrl = ctrl;
        end else if (exp_ready) begin
            m_v = 1'b0;
        end
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_v});
        if (m_v || m_clear) begin
            chk("out_rs1", {59'd0, bus.out_rs1}, {59'd0, m_rs1});
            chk("out_rs2", {59'd0, bus.out_rs2}, {59'd0, m_rs2});
            chk("out_rd", {59'd0, bus.out_rd}, {59'd0, m_rd});
            chk("out_imm", bus.out_imm, m_imm);
            chk("out_ctrl", {48'd0, bus.out_ctrl}, {48'd0, m_ctrl});
            chk("out_op1", bus.out_op1, arch(m_rs1));
            chk("out_op2", bus.out_op2, arch(m_rs2));
        end
        $display("cyc rst=%0d fl=%0d acc=%0d wb=%0d/x%0d v=%0d rd=%0d op1=%h op2=%h",
                 rst, fl, acc, we, wrd, bus.out_valid, bus.out_rd, bus.out_op1, bus.out_op2);
    endtask

    task automatic drive_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd);
        bus.in_valid = v;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_rd    = rd;
        bus.in_imm   = {$urandom, $urandom};
        bus.in_ctrl  = 16'($urandom);
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [63:0] data);
        bus.wb_regWrite = we;
        bus.wb_rd       = rd;
        bus.wb_data     = data;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
        rf_mem[0] = 64'h1234;
        rf_mem[5] = 64'h11;
        rf_mem[6] = 64'h22;
        m_v = 1'b0; m_clear = 1'b0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_imm = '0; m_ctrl = '0;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive_in(1'b0, 5'd0, 5'd0, 5'd0);
        drive_wb(1'b0, 5'd0, 64'd0);

        // Reset held two cycles
        cycle();
        cycle();
        chk("reset_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("reset_op1", bus.out_op1, 64'd0);
        chk("reset_op2", bus.out_op2, 64'd0);
        chk("reset_ready", {63'd0, bus.in_ready}, 64'd1);
        reset = 1'b0;
        cycle();

        // Basic fetch
        drive_in(1'b1, 5'd5, 5'd6, 5'd7);
        cycle();
        chk("basic_op1", bus.out_op1, 64'h11);
        chk("basic_op2", bus.out_op2, 64'h22);
        chk("basic_rd", {59'd0, bus.out_rd}, 64'd7);

        // Same-cycle writeback bypass on rs1
        drive_in(1'b1, 5'd5, 5'd6, 5'd8);
        drive_wb(1'b1, 5'd5, 64'hDEAD);
        cycle();
        chk("bypass_op1", bus.out_op1, 64'hDEAD);

        // Stall with snoop of rs2
        bus.out_ready = 1'b0;
        drive_in(1'b1, 5'd1, 5'd2, 5'd9);
        drive_wb(1'b1, 5'd6, 64'hBEEF);
        cycle();
        chk("snoop_op2", bus.out_op2, 64'hBEEF);
        chk("snoop_rd", {59'd0, bus.out_rd}, 64'd8);
        drive_wb(1'b0, 5'd0, 64'd0);
        cycle();
        chk("stall_ready", {63'd0, bus.in_ready}, 64'd0);

        // x0 operand ignores register file and writeback
        bus.out_ready = 1'b1;
        drive_in(1'b1, 5'd0, 5'd5, 5'd10);
        drive_wb(1'b1, 5'd0, 64'hFFFF);
        cycle();
        drive_wb(1'b0, 5'd0, 64'd0);
        chk("x0_op1", bus.out_op1, 64'd0);

        // Back-to-back stream with a flush on the second accept
        drive_in(1'b1, 5'd1, 5'd2, 5'd1);
        cycle();
        drive_in(1'b1, 5'd2, 5'd3, 5'd2);
        bus.flush = 1'b1;
        cycle();
        chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        bus.flush = 1'b0;
        drive_in(1'b1, 5'd3, 5'd4, 5'd3);
        cycle();
        chk("after_flush_rd", {59'd0, bus.out_rd}, 64'd3);
        drive_in(1'b0, 5'd0, 5'd0, 5'd0);
        cycle();

        // Random traffic on a narrow register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 99) < 2);
            bus.flush     = ($urandom_range(0, 99) < 5);
            bus.out_ready = ($urandom_range(0, 99) < 60);
            drive_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            drive_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                     {$urandom, $urandom});
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
